// File: rtl/weight_buffer_pingpong_pkg.sv
// ---------------------------------------------------------------------------
// weight_buffer_pingpong_pkg
// Shared definitions for the ping-pong float16 weight buffer:
//   - default word width, kernel side and lane count
//   - per-bank state encoding (EMPTY/FILL/FULL/DRAIN)
//   - read-mode encoding (conv / FC)
//   - small helpers that classify a bank state as writable or readable
// No ports (package).
// ---------------------------------------------------------------------------
package weight_buffer_pingpong_pkg;

    localparam int WB_DATA_WIDTH = 16;
    localparam int WB_KS_MAX     = 3;
    localparam int WB_PARA_Y     = 4;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2,
        BANK_DRAIN = 2'd3
    } bank_state_e;

    typedef enum logic {
        RD_CONV = 1'b0,
        RD_FC   = 1'b1
    } rd_mode_e;

    function automatic logic bank_writable(input bank_state_e s);
        return (s == BANK_EMPTY) || (s == BANK_FILL);
    endfunction

    function automatic logic bank_readable(input bank_state_e s);
        return (s == BANK_FULL) || (s == BANK_DRAIN);
    endfunction

endpackage

// File: rtl/weight_buffer_pingpong_bank.sv
// ---------------------------------------------------------------------------
// weight_buffer_pingpong_bank
// One weight bank: a slice-wide write port (KS_MAX*KS_MAX words per write)
// and PARA_Y registered read lanes. A lane whose word address is at or beyond
// DEPTH returns zero. Slice words that land beyond DEPTH are dropped, which
// matters when DEPTH is not a multiple of the slice size.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset (clears read registers only)
//   wr_en      write the slice this cycle (already qualified by the owner)
//   wr_addr    slice index
//   wr_din     slice data, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_en      capture the read lanes this cycle (already qualified)
//   lane_addr  PARA_Y word addresses, lane j at [j*LA_W +: LA_W]
//   rd_data    registered lanes, lane j at [j*DATA_WIDTH +: DATA_WIDTH];
//              holds when rd_en is low
// ---------------------------------------------------------------------------
module weight_buffer_pingpong_bank
    import weight_buffer_pingpong_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int KS_MAX     = WB_KS_MAX,
    parameter int PARA_Y     = WB_PARA_Y,
    parameter int DEPTH      = 1024,
    parameter int WR_AW      = 7,
    parameter int RD_AW      = 10,
    parameter int LA_W       = 20
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [WR_AW-1:0]                 wr_addr,
    input  logic [KS_MAX*KS_MAX*DATA_WIDTH-1:0] wr_din,
    input  logic                             rd_en,
    input  logic [PARA_Y*LA_W-1:0]           lane_addr,
    output logic [PARA_Y*DATA_WIDTH-1:0]     rd_data
);

    localparam int KK   = KS_MAX * KS_MAX;
    localparam int WA_W = RD_AW + $clog2(KK) + 1;
    localparam logic [WA_W-1:0] DEPTH_W = WA_W'(DEPTH);
    localparam logic [LA_W-1:0] DEPTH_L = LA_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [WA_W-1:0]       slice_base;
    logic [WA_W-1:0]       word_addr [KK];

    assign slice_base = WA_W'(wr_addr) * WA_W'(KK);

    always_comb begin
        for (int k = 0; k < KK; k++) begin
            word_addr[k] = slice_base + WA_W'(k);
        end
    end

    // RAM has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < KK; k++) begin
                if (word_addr[k] < DEPTH_W) begin
                    mem[word_addr[k][RD_AW-1:0]] <= wr_din[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            for (int j = 0; j < PARA_Y; j++) begin
                if (lane_addr[j*LA_W +: LA_W] < DEPTH_L) begin
                    rd_data[j*DATA_WIDTH +: DATA_WIDTH] <= mem[lane_addr[j*LA_W +: RD_AW]];
                end else begin
                    rd_data[j*DATA_WIDTH +: DATA_WIDTH] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/weight_buffer_pingpong.sv
// ---------------------------------------------------------------------------
// weight_buffer_pingpong
// Double-banked float16 weight buffer. The loader fills the write bank (wb)
// one kernel slice per cycle while the conv/FC engine reads PARA_Y lanes per
// cycle from the read bank (rb). Read latency is one registered cycle.
// Optional macro: WEIGHT_BUF_ERR_EN adds a sticky err[1:0] output
//   (bit0: write-side request while not ready, bit1: read-side request while
//   not ready or an accepted read with an out-of-range lane).
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   wr_en/addr/din    slice write into bank wb
//   wr_last           close bank wb (-> FULL) and move wb
//   wr_ready          bank wb is EMPTY or FILL
//   rd_en/mode/addr   lane read from bank rb (mode 0 conv, 1 FC)
//   fm_size           FC lane stride in words
//   rd_last           release bank rb (-> EMPTY) and move rb
//   rd_ready          bank rb is FULL or DRAIN
//   dout, dout_valid  lanes of the read accepted in the previous cycle
//   err               (WEIGHT_BUF_ERR_EN only) sticky error flags
//
// Per-bank state  | meaning
//   BANK_EMPTY    | released, free for the loader, no writes yet
//   BANK_FILL     | loader has written at least one slice
//   BANK_FULL     | closed by wr_last, waiting for the reader
//   BANK_DRAIN    | reader has issued at least one read
// ---------------------------------------------------------------------------
module weight_buffer_pingpong
    import weight_buffer_pingpong_pkg::*;
#(
    parameter int DATA_WIDTH  = WB_DATA_WIDTH,
    parameter int KS_MAX      = WB_KS_MAX,
    parameter int PARA_Y      = WB_PARA_Y,
    parameter int DEPTH       = 1024,
    parameter int CONV_STRIDE = 9,
    parameter int FM_W        = 8,
    parameter int WR_AW       = $clog2(DEPTH / (KS_MAX * KS_MAX)),
    parameter int RD_AW       = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [WR_AW-1:0]                    wr_addr,
    input  logic [KS_MAX*KS_MAX*DATA_WIDTH-1:0] wr_din,
    input  logic                                wr_last,
    output logic                                wr_ready,
    input  logic                                rd_en,
    input  logic                                rd_mode,
    input  logic [RD_AW-1:0]                    rd_addr,
    input  logic [FM_W-1:0]                     fm_size,
    input  logic                                rd_last,
    output logic                                rd_ready,
    output logic [PARA_Y*DATA_WIDTH-1:0]        dout,
    output logic                                dout_valid
`ifdef WEIGHT_BUF_ERR_EN
    ,
    output logic [1:0]                          err
`endif
);

    // Wide enough that no lane address can wrap.
    localparam int LA_W = RD_AW + FM_W + $clog2(PARA_Y);

    bank_state_e state_q [2];
    bank_state_e state_d [2];
    logic        wb_q, wb_d;
    logic        rb_q, rb_d;
    logic        rd_sel_q;
    logic        dout_valid_q;

    logic wr_acc, wr_done, rd_acc, rd_done;
    logic [PARA_Y*LA_W-1:0]       lane_addr;
    logic [PARA_Y*DATA_WIDTH-1:0] bank_rdata [2];

    assign wr_ready = bank_writable(state_q[wb_q]);
    assign rd_ready = bank_readable(state_q[rb_q]);

    assign wr_acc  = rst & wr_en   & wr_ready;
    assign wr_done = rst & wr_last & wr_ready;
    assign rd_acc  = rst & rd_en   & rd_ready;
    assign rd_done = rst & rd_last & rd_ready;

    always_comb begin
        lane_addr = '0;
        for (int j = 0; j < PARA_Y; j++) begin
            if (rd_mode == RD_FC) begin
                lane_addr[j*LA_W +: LA_W] = LA_W'(rd_addr) + LA_W'(j) * LA_W'(fm_size);
            end else begin
                lane_addr[j*LA_W +: LA_W] = LA_W'(rd_addr) + LA_W'(j * CONV_STRIDE);
            end
        end
    end

    // When wb==rb only one of wr_ready/rd_ready can be high, so write-side and
    // read-side updates never hit the same bank in one cycle.
    always_comb begin
        state_d = state_q;
        wb_d    = wb_q;
        rb_d    = rb_q;
        if (wr_acc && state_q[wb_q] == BANK_EMPTY) begin
            state_d[wb_q] = BANK_FILL;
        end
        if (wr_done) begin
            state_d[wb_q] = BANK_FULL;
            wb_d          = ~wb_q;
        end
        if (rd_acc && state_q[rb_q] == BANK_FULL) begin
            state_d[rb_q] = BANK_DRAIN;
        end
        if (rd_done) begin
            state_d[rb_q] = BANK_EMPTY;
            rb_d          = ~rb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q[0]   <= BANK_EMPTY;
            state_q[1]   <= BANK_EMPTY;
            wb_q         <= 1'b0;
            rb_q         <= 1'b0;
            rd_sel_q     <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wb_q         <= wb_d;
            rb_q         <= rb_d;
            dout_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_sel_q <= rb_q;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        weight_buffer_pingpong_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .KS_MAX     (KS_MAX),
            .PARA_Y     (PARA_Y),
            .DEPTH      (DEPTH),
            .WR_AW      (WR_AW),
            .RD_AW      (RD_AW),
            .LA_W       (LA_W)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_acc && (wb_q == 1'(b))),
            .wr_addr   (wr_addr),
            .wr_din    (wr_din),
            .rd_en     (rd_acc && (rb_q == 1'(b))),
            .lane_addr (lane_addr),
            .rd_data   (bank_rdata[b])
        );
    end

    // Both bank read registers hold, so following the last-read bank keeps
    // dout stable between reads; both reset to zero.
    assign dout       = bank_rdata[rd_sel_q];
    assign dout_valid = dout_valid_q;

`ifdef WEIGHT_BUF_ERR_EN
    logic [1:0] err_q;
    logic       lane_oor;

    always_comb begin
        lane_oor = 1'b0;
        for (int j = 0; j < PARA_Y; j++) begin
            if (lane_addr[j*LA_W +: LA_W] >= LA_W'(DEPTH)) begin
                lane_oor = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 2'b00;
        end else begin
            if ((wr_en || wr_last) && !wr_ready) begin
                err_q[0] <= 1'b1;
            end
            if (((rd_en || rd_last) && !rd_ready) || (rd_acc && lane_oor)) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_weight_buffer_pingpong.sv
// ---------------------------------------------------------------------------
// tb_weight_buffer_pingpong
// Self-checking bench for weight_buffer_pingpong (default parameters).
// The reference model treats the two banks as a two-entry queue of loaded
// banks plus a flat word array per bank; expected read data is pushed into a
// scoreboard queue and a separate monitor compares what the DUT presents.
// Define WEIGHT_BUF_ERR_EN to also check the sticky err output.
// ---------------------------------------------------------------------------
module tb_weight_buffer_pingpong;

    localparam int DW    = 16;
    localparam int KK    = 9;
    localparam int NLANE = 4;
    localparam int DEP   = 1024;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr_en;
    logic [6:0]           wr_addr;
    logic [KK*DW-1:0]     wr_din;
    logic                 wr_last;
    logic                 wr_ready;
    logic                 rd_en;
    logic                 rd_mode;
    logic [9:0]           rd_addr;
    logic [7:0]           fm_size;
    logic                 rd_last;
    logic                 rd_ready;
    logic [NLANE*DW-1:0]  dout;
    logic                 dout_valid;
`ifdef WEIGHT_BUF_ERR_EN
    logic [1:0]           err;
`endif

    weight_buffer_pingpong dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_din     (wr_din),
        .wr_last    (wr_last),
        .wr_ready   (wr_ready),
        .rd_en      (rd_en),
        .rd_mode    (rd_mode),
        .rd_addr    (rd_addr),
        .fm_size    (fm_size),
        .rd_last    (rd_last),
        .rd_ready   (rd_ready),
        .dout       (dout),
        .dout_valid (dout_valid)
`ifdef WEIGHT_BUF_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rst;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model
    logic [DW-1:0] mem_m [2][DEP];
    int            m_filled = 0;
    int            m_wi = 0;
    int            m_ri = 0;
    logic [1:0]    err_m = 2'b00;
    bit            known = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic set_idle();
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_din  = '0;
        wr_last = 1'b0;
        rd_en   = 1'b0;
        rd_mode = 1'b0;
        rd_addr = '0;
        fm_size = '0;
        rd_last = 1'b0;
    endtask

    // Called at negedge+1 with inputs set; checks the readies, advances the
    // model, pushes expectations, and returns at the next negedge+1.
    task automatic cycle();
        bit          wok, rok, oor;
        int          a, stride, nf;
        logic [63:0] e;
        #1;
        if (!rst) begin
            m_filled = 0;
            m_wi     = 0;
            m_ri     = 0;
            err_m    = 2'b00;
            known    = 1;
            exp_q.push_back('{is_rst: 1'b1, data: 64'h0});
        end else begin
            wok = (m_filled < 2);
            rok = (m_filled > 0);
            if (known) begin
                chk("wr_ready", 64'(wr_ready), 64'(wok));
                chk("rd_ready", 64'(rd_ready), 64'(rok));
`ifdef WEIGHT_BUF_ERR_EN
                chk("err", 64'(err), 64'(err_m));
`endif
            end
            if (wr_en && wok) begin
                for (int k = 0; k < KK; k++) begin
                    a = int'(wr_addr) * KK + k;
                    if (a < DEP) mem_m[m_wi][a] = wr_din[k*DW +: DW];
                end
            end
            if (rd_en && rok) begin
                e      = '0;
                oor    = 0;
                stride = rd_mode ? int'(fm_size) : 9;
                for (int j = 0; j < NLANE; j++) begin
                    a = int'(rd_addr) + j * stride;
                    if (a < DEP) e[j*DW +: DW] = mem_m[m_ri][a];
                    else oor = 1;
                end
                exp_q.push_back('{is_rst: 1'b0, data: e});
                if (oor) err_m[1] = 1'b1;
            end
            if ((wr_en || wr_last) && !wok) err_m[0] = 1'b1;
            if ((rd_en || rd_last) && !rok) err_m[1] = 1'b1;
            nf = m_filled;
            if (wr_last && wok) begin nf++; m_wi ^= 1; end
            if (rd_last && rok) begin nf--; m_ri ^= 1; end
            m_filled = nf;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic rand_read();
        rd_en   = 1'($urandom_range(0, 1));
        rd_mode = 1'($urandom_range(0, 1));
        rd_addr = 10'($urandom_range(0, DEP - 1));
        fm_size = 8'($urandom_range(0, 255));
    endtask

    task automatic rand_slice();
        for (int k = 0; k < KK; k++) wr_din[k*DW +: DW] = 16'($urandom);
    endtask

    // Monitor: one expectation per presented output, otherwise dout must hold.
    initial begin
        exp_t        it;
        logic [63:0] last_exp = '0;
        bit          mon_en   = 0;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                if (it.is_rst) begin
                    chk("reset dout_valid", 64'(dout_valid), 64'd0);
                    chk("reset dout", dout, 64'd0);
                    last_exp = '0;
                    mon_en   = 1;
                end else begin
                    chk("dout_valid", 64'(dout_valid), 64'd1);
                    chk("dout", dout, it.data);
                    last_exp = it.data;
                end
            end else if (mon_en) begin
                chk("idle dout_valid", 64'(dout_valid), 64'd0);
                chk("dout hold", dout, last_exp);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        set_idle();
        rst = 1'b0;
        @(negedge clk);
        #1;
        cycle();
        cycle();
        set_idle();
        cycle();

        // Bank0: word i holds 0x3C00+i; wr_last rides on the final slice.
        for (int s = 0; s < 114; s++) begin
            set_idle();
            wr_en   = 1'b1;
            wr_addr = 7'(s);
            for (int k = 0; k < KK; k++) wr_din[k*DW +: DW] = 16'(16'h3C00 + s * KK + k);
            wr_last = (s == 113);
            cycle();
        end
        set_idle();
        cycle();

        // Conv read, FC read, FC read running off the end of the bank.
        rd_en = 1'b1; rd_mode = 1'b0; rd_addr = 10'd2;
        cycle();
        rd_mode = 1'b1; fm_size = 8'd5; rd_addr = 10'd1;
        cycle();
        rd_addr = 10'd1020;
        cycle();
        set_idle();
        cycle();
        cycle();

        // Ping-pong: fill bank1 with random data while reading bank0.
        for (int s = 0; s < 114; s++) begin
            set_idle();
            wr_en   = 1'b1;
            wr_addr = 7'(s);
            rand_slice();
            rand_read();
            cycle();
        end
        set_idle();
        wr_last = 1'b1;
        rd_last = 1'b1;
        rd_en   = 1'b1;
        rd_addr = 10'd7;
        cycle();
        set_idle();
        cycle();
        rd_en = 1'b1; rd_addr = 10'd0;
        cycle();

        // Overrun: close bank0 with no writes, then try to write into it.
        set_idle();
        wr_last = 1'b1;
        cycle();
        set_idle();
        wr_en   = 1'b1;
        wr_addr = 7'd0;
        rand_slice();
        cycle();
        set_idle();
        wr_en   = 1'b1;
        wr_last = 1'b1;
        wr_addr = 7'd3;
        rand_slice();
        rand_read();
        cycle();
        set_idle();
        rd_last = 1'b1;
        cycle();
        set_idle();
        rd_en = 1'b1; rd_addr = 10'd0;
        cycle();
        rd_mode = 1'b1; fm_size = 8'd9; rd_addr = 10'd27;
        cycle();

        // Random traffic, including out-of-range slices and rare resets.
        for (int n = 0; n < 800; n++) begin
            set_idle();
            rst     = ($urandom_range(0, 99) != 0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 7'($urandom_range(0, 127));
            rand_slice();
            wr_last = ($urandom_range(0, 24) == 0);
            rand_read();
            rd_last = ($urandom_range(0, 24) == 0);
            cycle();
        end

        // Mid-operation reset with a read request in the same cycle.
        set_idle();
        wr_last = 1'b1;
        cycle();
        set_idle();
        rst   = 1'b0;
        rd_en = 1'b1;
        rd_addr = 10'd5;
        cycle();
        set_idle();
        rd_en = 1'b1;
        rd_addr = 10'd5;
        cycle();
        set_idle();
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
